neuron_mac: RTL and testbench



---
 rtl/nn_pkg.sv | 19 +
 rtl/neuron_mac_relu_sat.sv | 49 ++++
 rtl/neuron_mac.sv | 137 +++++++++++++
 tb/tb_neuron_mac.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neuron MAC engine: default data format,
// accumulator sizing helper and the frame-control state encoding.
package nn_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 12;

    // Wide enough to hold the sum of n full-width products without overflow.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } mac_state_t;

endpackage

// File: rtl/neuron_mac_relu_sat.sv
// relu_sat: rescales the wide fixed-point sum back to the activation format,
// narrows it to dataWidth and applies ReLU.
// Build option: NEURON_SAT_EN clamps the rescaled value to the signed
// dataWidth range before ReLU; without it the low dataWidth bits are kept.
module relu_sat
    import nn_pkg::*;
#(
    parameter int inW       = 2 * DATA_W + 5,
    parameter int dataWidth = DATA_W,
    parameter int fracBits  = FRAC_BITS
) (
    input  logic [inW-1:0]       sum,
    output logic [dataWidth-1:0] y
);

    logic signed [inW-1:0]       scaled;
    logic        [dataWidth-1:0] narrow;

`ifdef NEURON_SAT_EN
    localparam logic signed [inW-1:0] MAX_V =
        {{(inW - dataWidth + 1){1'b0}}, {(dataWidth - 1){1'b1}}};
    localparam logic signed [inW-1:0] MIN_V = ~MAX_V;

    // Arithmetic shift floors toward -inf, then clamp into range.
    always_comb begin
        scaled = $signed(sum) >>> fracBits;
        if (scaled > MAX_V) begin
            narrow = MAX_V[dataWidth-1:0];
        end else if (scaled < MIN_V) begin
            narrow = MIN_V[dataWidth-1:0];
        end else begin
            narrow = scaled[dataWidth-1:0];
        end
        y = narrow[dataWidth-1] ? '0 : narrow;
    end
`else
    // High bits are dropped on purpose: wrap-around narrowing.
    logic unused_hi;
    assign unused_hi = ^scaled[inW-1:dataWidth];

    // Arithmetic shift floors toward -inf, then keep the low bits.
    always_comb begin
        scaled = $signed(sum) >>> fracBits;
        narrow = scaled[dataWidth-1:0];
        y      = narrow[dataWidth-1] ? '0 : narrow;
    end
`endif

endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: per-neuron multiply-accumulate engine. Streams numWeight
// activations, reads the matching weights in lockstep, accumulates the
// products, adds the bias and emits one ReLU'd activation per frame.
// Build option: NEURON_SAT_EN (saturating narrowing inside relu_sat).
//
// Handshake: an activation transfers on a rising edge where
// in_valid && in_ready. in_ready is registered and only high in ACC;
// offers made while it is low are ignored, so upstream must hold its data.
// out_valid is a one-cycle pulse; out_data holds until the next frame.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int numWeight    = 30,
    parameter int addressWidth = (numWeight > 1) ? $clog2(numWeight) : 1,
    parameter int dataWidth    = DATA_W,
    parameter int fracBits     = FRAC_BITS,
    parameter logic [dataWidth-1:0] biasValue = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [dataWidth-1:0]    in_data,
    output logic                    in_ready,
    output logic                    w_ren,
    output logic [addressWidth-1:0] w_radd,
    input  logic [dataWidth-1:0]    w_data,
    output logic                    out_valid,
    output logic [dataWidth-1:0]    out_data,
    output logic [1:0]              state_dbg
);

    localparam int ACC_W  = acc_width(numWeight, dataWidth);
    localparam int PROD_W = 2 * dataWidth;
    // One spare bit so adding the scaled bias can never wrap.
    localparam int SUM_W  = ACC_W + 1;
    localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);

    mac_state_t              state;
    logic [addressWidth-1:0] idx;
    logic                    drain_cnt;
    logic                    accept;
    logic                    valid1;
    logic                    valid2;
    logic [dataWidth-1:0]    in_d1;
    logic [PROD_W-1:0]       prod;
    logic [ACC_W-1:0]        acc;
    logic [SUM_W-1:0]        sum;
    logic [dataWidth-1:0]    relu_y;

    assign accept    = in_valid && in_ready;
    assign w_ren     = accept;
    assign w_radd    = idx;
    assign state_dbg = state;

    assign sum = SUM_W'($signed(acc)) + (SUM_W'($signed(biasValue)) <<< fracBits);

    relu_sat #(
        .inW       (SUM_W),
        .dataWidth (dataWidth),
        .fracBits  (fracBits)
    ) u_relu_sat (
        .sum (sum),
        .y   (relu_y)
    );

    // Frame control: count accepts, drain the 2-deep pipeline, emit result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            idx       <= '0;
            drain_cnt <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ACC: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            idx       <= '0;
                            drain_cnt <= 1'b0;
                            in_ready  <= 1'b0;
                            state     <= DRAIN;
                        end else begin
                            idx <= idx + addressWidth'(1);
                        end
                    end
                end
                DRAIN: begin
                    in_ready  <= 1'b0;
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    out_valid <= 1'b1;
                    out_data  <= relu_y;
                    in_ready  <= 1'b1;
                    state     <= ACC;
                end
                default: begin
                    in_ready <= 1'b0;
                    state    <= ACC;
                end
            endcase
        end
    end

    // Datapath: align activation with its weight, multiply, accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1 <= 1'b0;
            valid2 <= 1'b0;
            in_d1  <= '0;
            prod   <= '0;
            acc    <= '0;
        end else begin
            valid1 <= accept;
            valid2 <= valid1;
            if (accept) begin
                in_d1 <= in_data;
            end
            if (valid1) begin
                prod <= $signed(in_d1) * $signed(w_data);
            end
            if (state == OUT) begin
                acc <= '0;
            end else if (valid2) begin
                acc <= acc + ACC_W'($signed(prod));
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac with numWeight=4, Q4.12 data. Two instances share
// one input stream: one with bias 0 and one with bias 0.5 (0x0800).
module tb_neuron_mac;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 2;
    localparam logic [DW-1:0] BIAS1 = 16'h0800;

`ifdef NEURON_SAT_EN
    localparam logic [DW-1:0] BIG_E0 = 16'h7FFF;
    localparam logic [DW-1:0] BIG_E1 = 16'h7FFF;
`else
    localparam logic [DW-1:0] BIG_E0 = 16'h0000;
    localparam logic [DW-1:0] BIG_E1 = 16'h07C0;
`endif

    typedef logic [N-1:0][DW-1:0] vecw_t;

    typedef struct packed {
        vecw_t         x;
        vecw_t         w;
        logic          bursty;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    // ---------------- DUTs and weight ROM model ----------------
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready0, w_ren0, out_valid0;
    logic          in_ready1, w_ren1, out_valid1;
    logic [AW-1:0] w_radd0, w_radd1;
    logic [DW-1:0] w_data0 = '0;
    logic [DW-1:0] w_data1 = '0;
    logic [DW-1:0] out_data0, out_data1;
    logic [1:0]    st0, st1;
    logic [DW-1:0] rom [N];

    neuron_mac #(.numWeight(N), .dataWidth(DW), .fracBits(12), .biasValue(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
        .w_ren(w_ren0), .w_radd(w_radd0), .w_data(w_data0),
        .out_valid(out_valid0), .out_data(out_data0), .state_dbg(st0)
    );

    neuron_mac #(.numWeight(N), .dataWidth(DW), .fracBits(12), .biasValue(BIAS1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .w_ren(w_ren1), .w_radd(w_radd1), .w_data(w_data1),
        .out_valid(out_valid1), .out_data(out_data1), .state_dbg(st1)
    );

    // Registered-read memory: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (w_ren0) w_data0 <= rom[w_radd0];
        if (w_ren1) w_data1 <= rom[w_radd1];
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    int            lat_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference: ReLU of the Q4.12 dot product plus bias, floor-rescaled.
    function automatic logic [DW-1:0] ref_neuron(input vecw_t x, input vecw_t w,
                                                 input logic [DW-1:0] bias);
        longint s;
        longint sc;
        logic [DW-1:0] v;
        s = 0;
        for (int i = 0; i < N; i++) begin
            s += longint'($signed(x[i])) * longint'($signed(w[i]));
        end
        s += longint'($signed(bias)) * 4096;
        sc = s >>> 12;
`ifdef NEURON_SAT_EN
        if (sc > 32767) sc = 32767;
        else if (sc < -32768) sc = -32768;
`endif
        v = sc[DW-1:0];
        return v[DW-1] ? '0 : v;
    endfunction

    // Every output pulse must match the oldest expected result and arrive
    // exactly 4 cycles after the frame's last accept.
    always @(negedge clk) begin
        if (out_valid0) begin
            if (exp_q0.size() == 0) begin
                check("spurious_out_valid0", 32'd1, 32'd0);
            end else begin
                check("out_data0", out_data0, exp_q0.pop_front());
                if (lat_q.size() != 0) check("latency", cyc - lat_q.pop_front(), 32'd4);
            end
        end
        if (out_valid1) begin
            if (exp_q1.size() == 0) check("spurious_out_valid1", 32'd1, 32'd0);
            else check("out_data1", out_data1, exp_q1.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Offers one frame; stalled offers must not read memory.
    task automatic send_frame(input vecw_t x, input vecw_t w, input logic bursty,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        int  i = 0;
        int  guard = 0;
        bit  gap = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) rom[k] = w[k];
        while (i < N) begin
            if (bursty && gap) begin
                in_valid = 1'b0;
                gap = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = x[i];
                #1;
                if (in_ready0) begin
                    check("w_ren_accept", {30'd0, w_ren0, w_ren1}, 32'd3);
                    check("w_radd0", w_radd0, i);
                    check("w_radd1", w_radd1, i);
                    if (i == N - 1) lat_q.push_back(cyc);
                    i++;
                    gap = 1'b1;
                end else begin
                    check("w_ren_stalled", {30'd0, w_ren0, w_ren1}, 32'd0);
                    check("stall_state", (st0 == nn_pkg::DRAIN || st0 == nn_pkg::OUT), 32'd1);
                end
            end
            guard++;
            if (guard > 100) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
            if (i < N) @(negedge clk);
        end
        exp_q0.push_back(e0);
        exp_q1.push_back(e1);
    endtask

    // ---------------- test sequence ----------------
    vec_t  vecs [6];
    vecw_t one4, half4, zero4, big4;

    initial begin
        one4  = {4{16'h1000}};
        half4 = {4{16'h0800}};
        zero4 = '0;
        big4  = {4{16'h7FFF}};
        // x/w concatenations list element 3 first, element 0 last.
        vecs[0] = '{x: half4, w: one4, bursty: 1'b0, e0: 16'h2000, e1: 16'h2800};
        vecs[1] = '{x: {16'h1000, 16'h1000, 16'h3000, 16'h1000},
                    w: {16'hF000, 16'h1000, 16'hF000, 16'h1000},
                    bursty: 1'b0, e0: 16'h0000, e1: 16'h0000};
        vecs[2] = '{x: half4, w: one4, bursty: 1'b1, e0: 16'h2000, e1: 16'h2800};
        vecs[3] = '{x: big4, w: big4, bursty: 1'b0, e0: BIG_E0, e1: BIG_E1};
        vecs[4] = '{x: zero4, w: one4, bursty: 1'b0, e0: 16'h0000, e1: 16'h0800};
        vecs[5] = '{x: zero4, w: one4, bursty: 1'b1, e0: 16'h0000, e1: 16'h0800};
        for (int k = 0; k < N; k++) rom[k] = '0;

        // Reset values while rst is held.
        #2;
        check("rst_in_ready", {31'd0, in_ready0}, 32'd0);
        check("rst_w_ren", {31'd0, w_ren0}, 32'd0);
        check("rst_w_radd", w_radd0, 32'd0);
        check("rst_out_valid", {30'd0, out_valid0, out_valid1}, 32'd0);
        check("rst_out_data", out_data0, 32'd0);
        check("rst_state", st0, nn_pkg::ACC);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_before_edge", {31'd0, in_ready0}, 32'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", {31'd0, in_ready0}, 32'd1);

        // Directed frames, back to back.
        for (int r = 0; r < 6; r++) begin
            send_frame(vecs[r].x, vecs[r].w, vecs[r].bursty, vecs[r].e0, vecs[r].e1);
        end
        idle(8);

        // Reset after two accepts: partial frame must vanish without a pulse.
        for (int k = 0; k < N; k++) rom[k] = 16'h1000;
        begin
            int got = 0;
            int guard = 0;
            while (got < 2 && guard < 20) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = 16'h7000;
                #1;
                if (in_ready0) got++;
                guard++;
            end
            check("pre_reset_accepts", got, 32'd2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", {31'd0, in_ready0}, 32'd0);
        check("midrst_w_radd", w_radd0, 32'd0);
        check("midrst_state", st0, nn_pkg::ACC);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(6);
        send_frame(half4, one4, 1'b0, 16'h2000, 16'h2800);

        // Randomized frames against the reference model.
        for (int r = 0; r < 10; r++) begin
            vecw_t x, w;
            for (int k = 0; k < N; k++) begin
                x[k] = DW'($urandom_range(0, 16'hFFFF));
                w[k] = (r < 5) ? DW'($urandom_range(0, 16'h1FFF)) - 16'h1000
                               : DW'($urandom_range(0, 16'hFFFF));
            end
            send_frame(x, w, 1'($urandom_range(0, 1)),
                       ref_neuron(x, w, 16'h0000), ref_neuron(x, w, BIAS1));
        end
        idle(1);

        // Wait for all expected results, bounded.
        for (int k = 0; k < 50; k++) begin
            if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
            @(negedge clk);
        end
        check("pending_results", exp_q0.size() + exp_q1.size(), 32'd0);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
